// File: rtl/program_load_sink.sv
// program_load_sink: responder end of the program-load write channel.
// AW line addresses and W data beats are queued independently, paired in
// arrival order, range/alignment checked, and issued as one registered,
// byte-strobed write per good pair into the RAM line port.
module program_load_sink #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 15,
  parameter int MEM_LINES  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          axi4_mm_clk,
  input  logic                          axi4_mm_rst_n,
  input  logic                          program_load_en,
  input  logic                          program_load_aw_valid,
  output logic                          program_load_aw_ready,
  input  logic [ADDR_WIDTH-1:0]         program_load_aw_payload_addr,
  input  logic                          program_load_w_valid,
  output logic                          program_load_w_ready,
  input  logic [DATA_WIDTH-1:0]         program_load_w_payload_data,
  input  logic [DATA_WIDTH/8-1:0]       program_load_w_payload_strb,
  output logic                          mem_wr_en,
  output logic [$clog2(MEM_LINES)-1:0]  mem_wr_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  output logic [DATA_WIDTH/8-1:0]       mem_wr_strb,
  output logic [$clog2(MEM_LINES):0]    lines_written,
  output logic                          load_done,
  output logic                          addr_error
);

  localparam int BPL  = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BPL);
  localparam int LW   = $clog2(MEM_LINES);
  localparam int CNTW = LW + 1;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c,
                                             input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return c + CW'(1);
      2'b01:   return c - CW'(1);
      default: return c;
    endcase
  endfunction

  // Saturating increment of the session line counter.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v >= CNTW'(MEM_LINES)) ? CNTW'(MEM_LINES) : v + CNTW'(1);
  endfunction

  // Queue storage and state
  logic [ADDR_WIDTH-1:0] aw_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] w_data_mem_q [FIFO_DEPTH];
  logic [BPL-1:0]        w_strb_mem_q [FIFO_DEPTH];
  logic [PW-1:0]         aw_wr_ptr_q, aw_rd_ptr_q, w_wr_ptr_q, w_rd_ptr_q;
  logic [CW-1:0]         aw_cnt_q, w_cnt_q;

  // Control/status registers
  logic                  live_q;
  logic                  en_q;
  logic [CNTW-1:0]       lines_q, lines_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Write-port registers
  logic                  wr_en_q;
  logic [LW-1:0]         wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [BPL-1:0]        wr_strb_q;

  logic aw_full, w_full, aw_empty, w_empty;
  logic aw_push, w_push, pair_pop;
  logic [ADDR_WIDTH-1:0]      head_addr;
  logic [OFFW-1:0]            head_off;
  logic [ADDR_WIDTH-OFFW-1:0] head_idx;
  logic addr_good, wr_good, wr_bad, en_rise;

  assign aw_full  = (aw_cnt_q == CW'(FIFO_DEPTH));
  assign w_full   = (w_cnt_q  == CW'(FIFO_DEPTH));
  assign aw_empty = (aw_cnt_q == '0);
  assign w_empty  = (w_cnt_q  == '0);

  // Readies come only from registered state and the session enable.
  assign program_load_aw_ready = live_q && program_load_en && !aw_full;
  assign program_load_w_ready  = live_q && program_load_en && !w_full;

  assign aw_push  = program_load_aw_valid && program_load_aw_ready;
  assign w_push   = program_load_w_valid  && program_load_w_ready;
  assign pair_pop = program_load_en && !aw_empty && !w_empty;

  assign head_addr = aw_mem_q[aw_rd_ptr_q];
  assign head_off  = head_addr[OFFW-1:0];
  assign head_idx  = head_addr[ADDR_WIDTH-1:OFFW];
  assign addr_good = (head_off == '0) && (int'(head_idx) < MEM_LINES);
  assign wr_good   = pair_pop && addr_good;
  assign wr_bad    = pair_pop && !addr_good;
  assign en_rise   = program_load_en && !en_q;

  // Queue payload storage; contents are don't-care while empty.
  always_ff @(posedge axi4_mm_clk) begin
    if (aw_push) aw_mem_q[aw_wr_ptr_q] <= program_load_aw_payload_addr;
    if (w_push) begin
      w_data_mem_q[w_wr_ptr_q] <= program_load_w_payload_data;
      w_strb_mem_q[w_wr_ptr_q] <= program_load_w_payload_strb;
    end
  end

  // Queue pointers and occupancy; dropping enable discards all queued entries.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      aw_wr_ptr_q <= '0;
      aw_rd_ptr_q <= '0;
      aw_cnt_q    <= '0;
      w_wr_ptr_q  <= '0;
      w_rd_ptr_q  <= '0;
      w_cnt_q     <= '0;
    end else if (!program_load_en) begin
      aw_wr_ptr_q <= '0;
      aw_rd_ptr_q <= '0;
      aw_cnt_q    <= '0;
      w_wr_ptr_q  <= '0;
      w_rd_ptr_q  <= '0;
      w_cnt_q     <= '0;
    end else begin
      if (aw_push)  aw_wr_ptr_q <= ptr_inc(aw_wr_ptr_q);
      if (pair_pop) aw_rd_ptr_q <= ptr_inc(aw_rd_ptr_q);
      if (w_push)   w_wr_ptr_q  <= ptr_inc(w_wr_ptr_q);
      if (pair_pop) w_rd_ptr_q  <= ptr_inc(w_rd_ptr_q);
      aw_cnt_q <= cnt_step(aw_cnt_q, aw_push, pair_pop);
      w_cnt_q  <= cnt_step(w_cnt_q,  w_push,  pair_pop);
    end
  end

  // Next session status: enable rising starts a fresh session.
  always_comb begin
    lines_d = lines_q;
    err_d   = err_q;
    if (en_rise) begin
      lines_d = '0;
      err_d   = 1'b0;
    end else begin
      if (wr_good) lines_d = sat_inc(lines_q);
      if (wr_bad)  err_d   = 1'b1;
    end
    done_d = (lines_d == CNTW'(MEM_LINES));
  end

  // Registered status, enable history and out-of-reset flag.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      live_q  <= 1'b0;
      en_q    <= 1'b0;
      lines_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      en_q    <= program_load_en;
      lines_q <= lines_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Write port: one-cycle strobe per good pair; payload holds between writes.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      wr_en_q <= wr_good;
      if (wr_good) begin
        wr_addr_q <= head_idx[LW-1:0];
        wr_data_q <= w_data_mem_q[w_rd_ptr_q];
        wr_strb_q <= w_strb_mem_q[w_rd_ptr_q];
      end
    end
  end

  assign mem_wr_en     = wr_en_q;
  assign mem_wr_addr   = wr_addr_q;
  assign mem_wr_data   = wr_data_q;
  assign mem_wr_strb   = wr_strb_q;
  assign lines_written = lines_q;
  assign load_done     = done_q;
  assign addr_error    = err_q;

endmodule

// File: tb/tb_program_load_sink.sv
// Testbench for program_load_sink: directed AW/W traffic with a write
// scoreboard (expected RAM writes queued by stimulus, popped by a monitor).
module tb_program_load_sink;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         aw_valid, aw_ready;
  logic [14:0]  aw_addr;
  logic         w_valid, w_ready;
  logic [511:0] w_data;
  logic [63:0]  w_strb;
  logic         mem_wr_en;
  logic [4:0]   mem_wr_addr;
  logic [511:0] mem_wr_data;
  logic [63:0]  mem_wr_strb;
  logic [5:0]   lines_written;
  logic         load_done;
  logic         addr_error;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [4:0]   addr;
    logic [511:0] data;
    logic [63:0]  strb;
  } wr_t;

  wr_t exp_q[$];

  program_load_sink #(
    .DATA_WIDTH(512), .ADDR_WIDTH(15), .MEM_LINES(32), .FIFO_DEPTH(2)
  ) dut (
    .axi4_mm_clk                  (clk),
    .axi4_mm_rst_n                (rst_n),
    .program_load_en              (en),
    .program_load_aw_valid        (aw_valid),
    .program_load_aw_ready        (aw_ready),
    .program_load_aw_payload_addr (aw_addr),
    .program_load_w_valid         (w_valid),
    .program_load_w_ready         (w_ready),
    .program_load_w_payload_data  (w_data),
    .program_load_w_payload_strb  (w_strb),
    .mem_wr_en                    (mem_wr_en),
    .mem_wr_addr                  (mem_wr_addr),
    .mem_wr_data                  (mem_wr_data),
    .mem_wr_strb                  (mem_wr_strb),
    .lines_written                (lines_written),
    .load_done                    (load_done),
    .addr_error                   (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] mk_data(input int n);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = {32'hC0DE0000 + 32'(n), 32'(i)};
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic exp_add(input int line, input logic [511:0] d, input logic [63:0] s);
    wr_t e;
    e.addr = 5'(line);
    e.data = d;
    e.strb = s;
    exp_q.push_back(e);
  endtask

  task automatic aw_push(input logic [14:0] a);
    int t;
    t = 0;
    aw_valid = 1'b1;
    aw_addr  = a;
    @(negedge clk);
    while (!aw_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL aw_timeout: got no aw_ready for addr %0h, required acceptance", a);
    end
    @(posedge clk);
    #1 aw_valid = 1'b0;
  endtask

  task automatic w_push(input logic [511:0] d, input logic [63:0] s);
    int t;
    t = 0;
    w_valid = 1'b1;
    w_data  = d;
    w_strb  = s;
    @(negedge clk);
    while (!w_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL w_timeout: got no w_ready, required acceptance");
    end
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n === 1'b1 && mem_wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got write to line %0d, required no write", mem_wr_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_wr_addr !== e.addr || mem_wr_data !== e.data || mem_wr_strb !== e.strb) begin
          n_bad++;
          $display("FAIL write_line: got addr=%0d data=%h strb=%h, required addr=%0d data=%h strb=%h",
                   mem_wr_addr, mem_wr_data, mem_wr_strb, e.addr, e.data, e.strb);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] tmp;
    n_cmp = 0;
    n_bad = 0;

    // Reset held with enable and valids high
    rst_n    = 1'b0;
    en       = 1'b1;
    aw_valid = 1'b1;
    w_valid  = 1'b1;
    aw_addr  = '0;
    w_data   = '0;
    w_strb   = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_lines", lines_written, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", addr_error, 0);
    en = 1'b0;
    aw_valid = 1'b0;
    w_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("en0_aw_ready", aw_ready, 0);
    chk("en0_w_ready", w_ready, 0);
    en = 1'b1;
    #1;
    chk("en1_aw_ready", aw_ready, 1);
    chk("en1_w_ready", w_ready, 1);

    // Full 32-line load, one pair per cycle
    for (int i = 0; i < 32; i++) exp_add(i, mk_data(i), '1);
    fork
      for (int i = 0; i < 32; i++) aw_push(15'(i * 64));
      for (int i = 0; i < 32; i++) w_push(mk_data(i), '1);
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!(aw_valid && aw_ready && w_valid && w_ready) && t < 20) begin
          @(negedge clk);
          t++;
        end
        chk("first_handshake_seen", 64'(t < 20), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("latency_cycle1_wr_en", mem_wr_en, 0);
        for (int i = 0; i < 32; i++) begin
          @(negedge clk);
          chk("burst_wr_en", mem_wr_en, 1);
          if (i == 30) begin
            chk("lines_at_31", lines_written, 31);
            chk("done_at_31", load_done, 0);
          end
          if (i == 31) begin
            chk("lines_at_32", lines_written, 32);
            chk("done_at_32", load_done, 1);
          end
        end
        @(negedge clk);
        chk("burst_end_wr_en", mem_wr_en, 0);
      end
    join
    drain();

    // Three addresses ahead of their data: AW queue fills at two
    for (int i = 5; i < 8; i++) exp_add(i, mk_data(100 + i), '1);
    fork
      begin
        aw_push(15'(5 * 64));
        aw_push(15'(6 * 64));
        @(negedge clk);
        chk("aw_full_ready", aw_ready, 0);
        aw_push(15'(7 * 64));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        for (int i = 5; i < 8; i++) w_push(mk_data(100 + i), '1);
      end
    join
    drain();
    @(negedge clk);
    chk("aw_ready_back", aw_ready, 1);
    chk("lines_saturated", lines_written, 32);
    chk("done_held", load_done, 1);

    // New session, then bad addresses
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("rise_lines_clear", lines_written, 0);
    chk("rise_done_clear", load_done, 0);
    chk("rise_err_clear", addr_error, 0);
    fork
      aw_push(15'h020);
      w_push(mk_data(200), '1);
    join
    fork
      aw_push(15'h800);
      w_push(mk_data(201), '1);
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bad_addr_err", addr_error, 1);
    chk("bad_addr_lines", lines_written, 0);
    tmp = mk_data(107);
    chk("hold_data_lo", mem_wr_data[63:0], tmp[63:0]);
    chk("hold_data_hi", mem_wr_data[511:448], tmp[511:448]);
    chk("hold_addr", mem_wr_addr, 7);
    exp_add(1, mk_data(301), '1);
    fork
      aw_push(15'h040);
      w_push(mk_data(301), '1);
    join
    drain();
    chk("good_after_bad_lines", lines_written, 1);
    chk("err_sticky", addr_error, 1);

    // Lines 2..10 (line 4 with a zero strobe), then drop enable with an AW pending
    for (int i = 2; i <= 10; i++) exp_add(i, mk_data(400 + i), (i == 4) ? 64'd0 : '1);
    fork
      for (int i = 2; i <= 10; i++) aw_push(15'(i * 64));
      for (int i = 2; i <= 10; i++) w_push(mk_data(400 + i), (i == 4) ? 64'd0 : '1);
    join
    drain();
    chk("ten_lines", lines_written, 10);
    chk("ten_not_done", load_done, 0);
    aw_push(15'(20 * 64));
    en = 1'b0;
    #1;
    chk("endrop_aw_ready", aw_ready, 0);
    chk("endrop_w_ready", w_ready, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("endrop_lines_held", lines_written, 10);
    chk("endrop_err_held", addr_error, 1);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("reraise_lines_clear", lines_written, 0);
    chk("reraise_err_clear", addr_error, 0);
    exp_add(3, mk_data(503), 64'h00FF_00FF_0F0F_F0F0);
    fork
      aw_push(15'(3 * 64));
      w_push(mk_data(503), 64'h00FF_00FF_0F0F_F0F0);
    join
    drain();
    chk("reraise_one_line", lines_written, 1);

    // Asynchronous reset in the middle of traffic
    @(posedge clk);
    #1;
    aw_valid = 1'b1;
    w_valid  = 1'b1;
    aw_addr  = 15'(4 * 64);
    w_data   = mk_data(600);
    w_strb   = '1;
    @(posedge clk);
    #1;
    aw_addr = 15'(5 * 64);
    w_data  = mk_data(601);
    @(posedge clk);
    #1;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    chk("pre_reset_wr_en", mem_wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wr_en", mem_wr_en, 0);
    chk("async_rst_aw_ready", aw_ready, 0);
    chk("async_rst_w_ready", w_ready, 0);
    chk("async_rst_lines", lines_written, 0);
    chk("async_rst_addr", mem_wr_addr, 0);
    chk("async_rst_data_lo", mem_wr_data[63:0], 0);
    chk("async_rst_strb", mem_wr_strb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_aw_ready", aw_ready, 1);
    chk("post_rst_lines", lines_written, 0);
    exp_add(9, mk_data(609), '1);
    fork
      aw_push(15'(9 * 64));
      w_push(mk_data(609), '1);
    join
    drain();
    chk("post_rst_one_line", lines_written, 1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
